// File: rtl/demux_striping_n.sv
// Round-robin striping demultiplexer: consecutive accepted words fill lanes 0..LANES-1.
// Each completed (or flushed) group leaves as one aligned, registered beat.
module demux_striping_n #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 2,
  parameter int PTR_W      = 1
) (
  input  logic                        clk_2f,
  input  logic                        reset_L,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        valid_in,
  input  logic                        flush,
  output logic [LANES*DATA_WIDTH-1:0] data_out,
  output logic [LANES-1:0]            valid_out,
  output logic [PTR_W-1:0]            lane_ptr
);

  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

  logic [PTR_W-1:0]                   ptr_reg, ptr_next;
  logic [LANES-2:0]                   fill_reg, fill_next;
  logic [LANES-2:0]                   fill_with;
  logic [LANES-2:0]                   accept_onehot;
  logic [LANES-2:0][DATA_WIDTH-1:0]   stage_reg, stage_next;
  logic [LANES*DATA_WIDTH-1:0]        data_out_reg, data_out_next;
  logic [LANES-1:0]                   valid_out_reg, valid_out_next;

  logic last_lane;
  logic complete;
  logic restart;

  assign last_lane = (ptr_reg == LAST_LANE);
  assign complete  = valid_in && last_lane;
  // A flush on the completing cycle is just a normal completion, so both restart the group.
  assign restart   = complete || flush;

  genvar gi;
  generate
    for (gi = 0; gi < LANES - 1; gi++) begin : g_stage
      assign accept_onehot[gi] = valid_in && (ptr_reg == PTR_W'(gi));
      assign stage_next[gi]    = accept_onehot[gi] ? data_in : stage_reg[gi];
      // On a flush the same-cycle word bypasses the stage straight into the beat.
      assign data_out_next[gi*DATA_WIDTH +: DATA_WIDTH] =
          valid_out_next[gi] ? (accept_onehot[gi] ? data_in : stage_reg[gi])
                             : data_out_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign data_out_next[(LANES-1)*DATA_WIDTH +: DATA_WIDTH] =
      complete ? data_in : data_out_reg[(LANES-1)*DATA_WIDTH +: DATA_WIDTH];

  assign fill_with = fill_reg | accept_onehot;

  always_comb begin
    valid_out_next = '0;
    if (complete) begin
      valid_out_next = '1;
    end else if (flush) begin
      valid_out_next = {1'b0, fill_with};
    end
  end

  always_comb begin
    ptr_next  = ptr_reg;
    fill_next = fill_with;
    if (restart) begin
      ptr_next  = '0;
      fill_next = '0;
    end else if (valid_in) begin
      ptr_next  = ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      ptr_reg       <= '0;
      fill_reg      <= '0;
      stage_reg     <= '0;
      data_out_reg  <= '0;
      valid_out_reg <= '0;
    end else begin
      ptr_reg       <= ptr_next;
      fill_reg      <= fill_next;
      stage_reg     <= stage_next;
      data_out_reg  <= data_out_next;
      valid_out_reg <= valid_out_next;
    end
  end

  assign data_out  = data_out_reg;
  assign valid_out = valid_out_reg;
  assign lane_ptr  = ptr_reg;

endmodule
